// File: rtl/atan2_arbiter_if.sv
// Bundles the requester, result and engine buses of atan2_arbiter.
// master = requesters plus engine side, slave = the arbiter.
interface atan2_arbiter_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]       req_valid;
  logic [CHANNELS-1:0]       req_ready;
  logic [CHANNELS*WIDTH-1:0] req_y;
  logic [CHANNELS*WIDTH-1:0] req_x;
  logic [CHANNELS-1:0]       res_valid;
  logic [CHANNELS-1:0]       res_ready;
  logic [CHANNELS*16-1:0]    res_data;
  logic [WIDTH-1:0]          eng_y;
  logic [WIDTH-1:0]          eng_x;
  logic [15:0]               eng_result;
  logic                      eng_busy;

  modport master (
    output req_valid, req_y, req_x, res_ready, eng_result,
    input  req_ready, res_valid, res_data, eng_y, eng_x, eng_busy
  );

  modport slave (
    input  req_valid, req_y, req_x, res_ready, eng_result,
    output req_ready, res_valid, res_data, eng_y, eng_x, eng_busy
  );
endinterface

// File: rtl/atan2_arbiter.sv
// Shares one DELAY-latency atan2 engine between CHANNELS requesters; result visible DELAY+1 cycles
// after accept, one sample in flight per channel so result backpressure never stalls the engine. ATAN2_ARB_PRIO_EN: channel 0 strict priority.
module atan2_arbiter #(
  parameter int WIDTH    = 16,
  parameter int DELAY    = 8,
  parameter int CHANNELS = 4
) (
  input  logic           clk,
  input  logic           reset,
  atan2_arbiter_if.slave bus
);
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  typedef logic [IW-1:0] idx_t;

  logic [CHANNELS-1:0]      busy_q, busy_d;
  logic [CHANNELS-1:0]      res_vld_q, res_vld_d;
  logic [CHANNELS*16-1:0]   res_dat_q, res_dat_d;
  idx_t                     rr_q, rr_d;
  logic [WIDTH-1:0]         eng_y_q, eng_y_d;
  logic [WIDTH-1:0]         eng_x_q, eng_x_d;
  logic                     iss_vld_q;
  idx_t                     iss_idx_q;
  logic [DELAY-1:0]         tag_vld_q, tag_vld_d;
  logic [DELAY-1:0][IW-1:0] tag_idx_q, tag_idx_d;
  logic                     eng_busy_q, eng_busy_d;

  logic [CHANNELS-1:0] elig;
  logic [CHANNELS-1:0] grant;
  logic [CHANNELS-1:0] consume;
  logic                acc;
  idx_t                gnt_idx;
  idx_t                rr_nxt;
  int                  cand;

  // First eligible channel at or after rr wins.
  always_comb begin
    elig    = bus.req_valid & ~busy_q;
    acc     = 1'b0;
    gnt_idx = '0;
    cand    = 0;
`ifdef ATAN2_ARB_PRIO_EN
    if (elig[0]) acc = 1'b1;
`endif
    for (int off = 0; off < CHANNELS; off++) begin
      cand = int'(rr_q) + off;
      if (cand >= CHANNELS) cand = cand - CHANNELS;
      if (!acc && elig[idx_t'(cand)]) begin
        acc     = 1'b1;
        gnt_idx = idx_t'(cand);
      end
    end
    grant  = {{(CHANNELS-1){1'b0}}, acc} << gnt_idx;
    rr_nxt = (int'(gnt_idx) == CHANNELS - 1) ? '0 : idx_t'(gnt_idx + 1'b1);
  end

  assign consume = res_vld_q & bus.res_ready;

  // The issue register travels with eng_y/eng_x; the DELAY tag stages then track the
  // engine's own stages, so the last stage is valid exactly while eng_result is the answer.
  always_comb begin
    rr_d    = rr_q;
    eng_y_d = eng_y_q;
    eng_x_d = eng_x_q;
    if (acc) begin
      eng_y_d = bus.req_y[gnt_idx*WIDTH +: WIDTH];
      eng_x_d = bus.req_x[gnt_idx*WIDTH +: WIDTH];
`ifdef ATAN2_ARB_PRIO_EN
      if (gnt_idx != '0) rr_d = rr_nxt;
`else
      rr_d = rr_nxt;
`endif
    end

    busy_d    = (busy_q | grant) & ~consume;
    res_vld_d = res_vld_q & ~consume;
    res_dat_d = res_dat_q;
    if (tag_vld_q[DELAY-1]) begin
      res_vld_d[tag_idx_q[DELAY-1]]          = 1'b1;
      res_dat_d[tag_idx_q[DELAY-1]*16 +: 16] = bus.eng_result;
    end

    tag_vld_d  = {tag_vld_q[DELAY-2:0], iss_vld_q};
    tag_idx_d  = {tag_idx_q[DELAY-2:0], iss_idx_q};
    eng_busy_d = acc | (|tag_vld_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q       <= '0;
      busy_q     <= '0;
      res_vld_q  <= '0;
      res_dat_q  <= '0;
      eng_y_q    <= '0;
      eng_x_q    <= '0;
      iss_vld_q  <= 1'b0;
      iss_idx_q  <= '0;
      tag_vld_q  <= '0;
      tag_idx_q  <= '0;
      eng_busy_q <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      busy_q     <= busy_d;
      res_vld_q  <= res_vld_d;
      res_dat_q  <= res_dat_d;
      eng_y_q    <= eng_y_d;
      eng_x_q    <= eng_x_d;
      iss_vld_q  <= acc;
      iss_idx_q  <= gnt_idx;
      tag_vld_q  <= tag_vld_d;
      tag_idx_q  <= tag_idx_d;
      eng_busy_q <= eng_busy_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.res_valid = res_vld_q;
  assign bus.res_data  = res_dat_q;
  assign bus.eng_y     = eng_y_q;
  assign bus.eng_x     = eng_x_q;
  assign bus.eng_busy  = eng_busy_q;
endmodule

// File: tb/tb_atan2_arbiter.sv
// Bench for atan2_arbiter: a behavioural atan2 engine, a transaction-level model of the
// scheduler, directed scenarios with literal expectations, and randomized traffic.
module tb_atan2_arbiter;
  localparam int W = 16;
  localparam int D = 8;
  localparam int C = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  atan2_arbiter_if #(.WIDTH(W), .CHANNELS(C)) bif ();
  atan2_arbiter #(.WIDTH(W), .DELAY(D), .CHANNELS(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] ref_atan2(input logic [W-1:0] y, input logic [W-1:0] x);
    real a;
    int  r;
    a = $atan2(real'(int'($signed(y))), real'(int'($signed(x)))) * 32768.0 / 3.141592653589793;
    if (a >= 0.0) r = $rtoi(a + 0.5);
    else          r = -$rtoi(0.5 - a);
    return 16'(r);
  endfunction

  // Engine: DELAY register stages, never reset.
  logic [15:0] eng_pipe [D];
  always @(posedge clk) begin
    eng_pipe[0] <= ref_atan2(bif.eng_y, bif.eng_x);
    for (int i = 1; i < D; i++) eng_pipe[i] <= eng_pipe[i-1];
  end
  assign bif.eng_result = eng_pipe[D-1];

  typedef struct {
    int          ch;
    logic [15:0] val;
    int          due;
  } flight_t;

  // Scheduler model
  int             m_rr;
  logic [C-1:0]   m_busy;
  logic [C-1:0]   m_resv;
  logic [C*16-1:0] m_resd;
  logic [W-1:0]   m_eng_y, m_eng_x;
  flight_t        m_flight[$];
  int             ecount = 0;

  // Requester / consumer state
  logic [C-1:0] hold_vld;
  logic [W-1:0] hold_y [C];
  logic [W-1:0] hold_x [C];
  logic [C-1:0] res_rdy;

  logic [C-1:0]    last_ready, last_resv;
  logic [C*16-1:0] last_resd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_busy = '0; m_resv = '0; m_resd = '0;
    m_eng_y = '0; m_eng_x = '0;
    m_flight.delete();
    hold_vld = '0;
  endtask

  function automatic int model_grant(input logic [C-1:0] v);
`ifdef ATAN2_ARB_PRIO_EN
    if (v[0] && !m_busy[0]) return 0;
`endif
    for (int off = 0; off < C; off++) begin
      int ch;
      ch = (m_rr + off) % C;
      if (v[ch] && !m_busy[ch]) return ch;
    end
    return -1;
  endfunction

  task automatic set_req(input int ch, input logic [W-1:0] y, input logic [W-1:0] x);
    hold_vld[ch] = 1'b1;
    hold_y[ch]   = y;
    hold_x[ch]   = x;
  endtask

  task automatic rand_inputs(input int pct0, input int pct, input int prdy, input logic [C-1:0] rdy_mask);
    for (int i = 0; i < C; i++) begin
      if (!hold_vld[i] && int'($urandom_range(99)) < ((i == 0) ? pct0 : pct))
        set_req(i, W'($urandom), W'($urandom));
      res_rdy[i] = rdy_mask[i] && (int'($urandom_range(99)) < prdy);
    end
  endtask

  // One clock cycle: drive, compare against the model, advance the model, cross the edge.
  task automatic tick();
    logic [C*W-1:0] py, px;
    logic [C-1:0]   er;
    int             g;
    flight_t        f;
    for (int i = 0; i < C; i++) begin
      py[i*W +: W] = hold_y[i];
      px[i*W +: W] = hold_x[i];
    end
    bif.req_valid = hold_vld;
    bif.req_y     = py;
    bif.req_x     = px;
    bif.res_ready = res_rdy;
    #1;
    g  = model_grant(hold_vld);
    er = (g >= 0) ? (C'(1) << g) : '0;
    check("req_ready", 64'(bif.req_ready), 64'(er));
    check("res_valid", 64'(bif.res_valid), 64'(m_resv));
    check("res_data",  64'(bif.res_data),  64'(m_resd));
    check("eng_busy",  64'(bif.eng_busy),  64'(m_flight.size() != 0));
    check("eng_y",     64'(bif.eng_y),     64'(m_eng_y));
    check("eng_x",     64'(bif.eng_x),     64'(m_eng_x));
    last_ready = bif.req_ready;
    last_resv  = bif.res_valid;
    last_resd  = bif.res_data;

    if (g >= 0) begin
      m_busy   = m_busy | (C'(1) << g);
      m_eng_y  = hold_y[g];
      m_eng_x  = hold_x[g];
      f.ch     = g;
      f.val    = ref_atan2(hold_y[g], hold_x[g]);
      f.due    = ecount + D + 1;
      m_flight.push_back(f);
`ifdef ATAN2_ARB_PRIO_EN
      if (g != 0) m_rr = (g + 1) % C;
`else
      m_rr = (g + 1) % C;
`endif
      hold_vld = hold_vld & ~(C'(1) << g);
    end
    for (int i = 0; i < C; i++) begin
      if (m_resv[i] && res_rdy[i]) begin
        m_resv[i] = 1'b0;
        m_busy[i] = 1'b0;
      end
    end
    while (m_flight.size() != 0 && m_flight[0].due == ecount) begin
      f = m_flight.pop_front();
      m_resv[f.ch]           = 1'b1;
      m_resd[f.ch*16 +: 16]  = f.val;
    end
    ecount++;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [W-1:0]  ay [4] = '{16'h0001, 16'h0000, 16'hFFF9, 16'h0003};
  logic [W-1:0]  ax [4] = '{16'h0001, 16'hFFFB, 16'h0007, 16'h0000};
  logic [15:0]   ares [4] = '{16'h2000, 16'h8000, 16'hE000, 16'h4000};

  initial begin
    int          first_seen [4];
    logic [15:0] seen_dat [4];
    int          cnt, bad_grant, data_changes, have, grants1;
    logic [15:0] held;

    reset = 1'b1;
    model_reset();
    res_rdy       = '1;
    bif.req_valid = '0;
    bif.req_y     = '0;
    bif.req_x     = '0;
    bif.res_ready = '1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_res_valid", 64'(bif.res_valid), 64'h0);
    check("reset_res_data",  64'(bif.res_data),  64'h0);
    check("reset_eng_busy",  64'(bif.eng_busy),  64'h0);
    check("reset_eng_y",     64'(bif.eng_y),     64'h0);
    check("reset_req_ready", 64'(bif.req_ready), 64'h0);
    @(negedge clk);

    // All four channels in one cycle, pointer at 0.
    for (int i = 0; i < 4; i++) set_req(i, ay[i], ax[i]);
    for (int n = 0; n < 4; n++) begin
      tick();
      check($sformatf("all4_grant%0d", n), 64'(last_ready), 64'(1) << n);
    end
    for (int i = 0; i < 4; i++) first_seen[i] = -1;
    for (int t = 0; t < 20; t++) begin
      tick();
      for (int i = 0; i < 4; i++)
        if (last_resv[i] && first_seen[i] < 0) begin
          first_seen[i] = t;
          seen_dat[i]   = last_resd[i*16 +: 16];
        end
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("all4_time%0d", i), 64'(first_seen[i]), 64'(D - 2 + i));
      check($sformatf("all4_data%0d", i), 64'(seen_dat[i]),   64'(ares[i]));
    end

    // Single request on channel 2.
    set_req(2, 16'h0003, 16'h0000);
    tick();
    check("single_grant", 64'(last_ready), 64'h4);
    first_seen[2] = -1;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (last_resv[2] && first_seen[2] < 0) begin
        first_seen[2] = t;
        seen_dat[2]   = last_resd[2*16 +: 16];
      end
    end
    check("single_time", 64'(first_seen[2]), 64'(D + 1));
    check("single_data", 64'(seen_dat[2]),   64'h4000);

    // Pointer wrap: rr is 3 after the channel 2 grant.
    set_req(3, 16'h0005, 16'h0005);
    set_req(0, 16'h0002, 16'h0009);
    tick();
`ifdef ATAN2_ARB_PRIO_EN
    check("wrap_first",  64'(last_ready), 64'h1);
    tick();
    check("wrap_second", 64'(last_ready), 64'h8);
`else
    check("wrap_first",  64'(last_ready), 64'h8);
    tick();
    check("wrap_second", 64'(last_ready), 64'h1);
`endif
    repeat (15) tick();

    // Result backpressure on channel 1.
    bad_grant = 0; data_changes = 0; have = 0; held = '0;
    repeat (80) begin
      rand_inputs(60, 60, 80, 4'b1101);
      tick();
      if (last_ready[1] && last_resv[1]) bad_grant++;
      if (last_resv[1]) begin
        if (have != 0 && last_resd[31:16] != held) data_changes++;
        held = last_resd[31:16];
        have = 1;
      end
    end
    check("bp_no_regrant",  64'(bad_grant),    64'h0);
    check("bp_data_stable", 64'(data_changes), 64'h0);
    check("bp_result_held", 64'(have),         64'h1);
    grants1 = 0;
    repeat (40) begin
      rand_inputs(60, 60, 80, 4'b1111);
      tick();
      if (last_ready[1]) grants1++;
    end
    check("bp_regrant", 64'(grants1 > 0), 64'h1);

    // Channel 0 requesting continuously.
    repeat (200) begin
      rand_inputs(100, 70, 70, 4'b1111);
      tick();
    end

    // Reset while samples are in flight.
    hold_vld = '0;
    res_rdy  = '1;
    repeat (20) tick();
    set_req(0, 16'h0011, 16'h0022);
    set_req(3, 16'h0033, 16'h0044);
    tick();
    tick();
    tick();
    check("mid_busy_before_reset", 64'(bif.eng_busy), 64'h1);
    tick();
    #1;
    reset         = 1'b1;
    hold_vld      = '0;
    bif.req_valid = '0;
    #1;
    check("mid_rst_res_valid", 64'(bif.res_valid), 64'h0);
    check("mid_rst_res_data",  64'(bif.res_data),  64'h0);
    check("mid_rst_eng_busy",  64'(bif.eng_busy),  64'h0);
    check("mid_rst_eng_y",     64'(bif.eng_y),     64'h0);
    check("mid_rst_eng_x",     64'(bif.eng_x),     64'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (D + 4) begin
      tick();
      if (last_resv != '0) cnt++;
    end
    check("post_reset_no_result", 64'(cnt), 64'h0);

    // Mixed random traffic.
    repeat (400) begin
      rand_inputs(50, 50, 70, 4'b1111);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its end, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
